// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide unit owning the HI/LO pair
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wd,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div, r_dbz, r_sa, r_sb, r_done, r_dz;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb, r_rem, r_hi, r_lo;

    logic               w_accept, w_commit, w_idle_wr, w_sa, w_sb, w_bz;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rmd, w_res_hi, w_res_lo;
    logic [WIDTH:0]     w_sum, w_trial, w_diff;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept  = i_start && r_state == S_IDLE;
    assign w_commit  = r_state == S_FIX && !i_abort;
    assign w_idle_wr = r_state == S_IDLE && !i_start;
    assign w_sa      = i_op[0] & i_a[WIDTH-1];
    assign w_sb      = i_op[0] & i_b[WIDTH-1];
    assign w_bz      = i_b == '0;
    assign w_mag_a   = w_sa ? -i_a : i_a;
    assign w_mag_b   = w_sb ? -i_b : i_b;

    // multiply step: acc = {partial product, remaining multiplier bits}
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    // divide step: shift next dividend bit into the WIDTH+1 bit partial remainder
    assign w_trial   = {r_rem, r_acc[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_opb};

    // sign correction; flags are zero for unsigned ops so these pass through
    assign w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo     = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rmd     = r_sa ? -r_rem : r_rem;
    assign w_res_hi  = r_dbz ? r_acc[WIDTH-1:0] : r_div ? w_rmd : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo  = r_dbz ? '1 : r_div ? w_quo : w_prod[WIDTH-1:0];

    assign o_busy        = r_state != S_IDLE;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next state: abort cancels any non-idle state, including the commit cycle
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) begin
            if (i_start) w_next = i_op[1] ? (w_bz ? S_FIX : S_DIV) : S_MUL;
        end else if (i_abort) begin
            w_next = S_IDLE;
        end else if (r_state == S_FIX) begin
            w_next = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
            w_next = S_FIX;
        end
    end

    // operand capture and one iteration per edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_dbz <= 1'b0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_acc <= '0;
            r_opb <= '0;
            r_rem <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(WIDTH);
            r_div <= i_op[1];
            r_dbz <= i_op[1] & w_bz;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_opb <= i_op[1] ? w_mag_b : w_mag_a;
            r_acc <= {{WIDTH{1'b0}}, i_op[1] ? (w_bz ? i_a : w_mag_a) : w_mag_b};
            r_rem <= '0;
        end else if (r_state == S_MUL) begin
            r_cnt <= r_cnt - 1'b1;
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
        end else if (r_state == S_DIV) begin
            r_cnt <= r_cnt - 1'b1;
            r_rem <= w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
        end
    end

    // HI/LO: operation commit or idle MTHI/MTLO, plus registered status pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_dz   <= w_commit & r_dbz;
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_idle_wr) begin
                if (i_wr_hi) r_hi <= i_wd;
                if (i_wr_lo) r_lo <= i_wd;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written corner sequences for muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wd = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;
    int           checks = 0, failures = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
        int           lat;
    } vec_t;
    vec_t vecs[14];

    muldiv_unit #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .i_abort(abort), .i_wr_hi(wr_hi), .i_wr_lo(wr_lo), .i_wd(wd),
        .o_busy(busy), .o_done(done), .o_div_by_zero(dz), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, bc;
        logic seen;
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[6]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vecs[7]  = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};
        vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33};
        vecs[11] = '{2'b10, 32'h12345678, 32'h00000100, 32'h00000078, 32'h00123456, 1'b0, 33};
        vecs[12] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};
        vecs[13] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};

        repeat (3) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dz", {31'b0, dz}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        tick();

        // each vector starts in the done cycle of the previous one (back-to-back)
        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            bc = busy ? 1 : 0;
            n = 0;
            while (!done && n < 40) begin
                tick();
                n++;
                if (busy) bc++;
            end
            chk($sformatf("vec%0d_latency", i), n, vecs[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].lat);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("vec%0d_dz", i), {31'b0, dz}, {31'b0, vecs[i].dz});
        end

        // both MT strobes in one idle cycle, then MTHI alone
        wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h01234567;
        tick();
        wr_lo = 1'b0; wd = 32'hA5A5A5A5;
        tick();
        wr_hi = 1'b0;
        chk("mt_hi", hi, 32'hA5A5A5A5);
        chk("mt_lo", lo, 32'h01234567);

        // abort during multiply: no commit, no done
        launch(2'b01, 32'd3, 32'd5);
        repeat (9) tick();
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy_after", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);
        chk("abort_hi_hold", hi, 32'hA5A5A5A5);
        chk("abort_lo_hold", lo, 32'h01234567);

        // abort in the commit cycle wins
        launch(2'b00, 32'd2, 32'd3);
        repeat (32) tick();
        chk("fix_abort_busy_before", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("fix_abort_done", {31'b0, done}, 32'd0);
        chk("fix_abort_busy", {31'b0, busy}, 32'd0);
        chk("fix_abort_lo_hold", lo, 32'h01234567);

        // abort while idle does not block a same-cycle start; wr_lo while busy dropped
        abort = 1'b1;
        launch(2'b00, 32'd6, 32'd7);
        abort = 1'b0;
        chk("idle_abort_start_busy", {31'b0, busy}, 32'd1);
        wr_lo = 1'b1; wd = 32'hDEADBEEF;
        tick();
        wr_lo = 1'b0;
        wait_done(n);
        chk("busy_wrlo_latency", n, 32);
        chk("busy_wrlo_lo", lo, 32'd42);
        chk("busy_wrlo_hi", hi, 32'd0);

        // start and wr_lo in the same cycle: operation result wins
        wr_lo = 1'b1; wd = 32'h11111111;
        launch(2'b00, 32'd2, 32'd5);
        wr_lo = 1'b0;
        wait_done(n);
        chk("start_wrlo_lo", lo, 32'd10);

        // start while busy ignored
        launch(2'b00, 32'd9, 32'd9);
        repeat (5) tick();
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("busy_start_latency", n, 27);
        chk("busy_start_lo", lo, 32'd81);
        chk("busy_start_hi", hi, 32'd0);
        tick();
        chk("busy_start_no_second", {31'b0, busy}, 32'd0);

        // asynchronous reset mid-divide
        launch(2'b10, 32'd100, 32'd7);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after_rst_busy", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
